// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   Instruction queue between the fetch stage and the decode stage. Buffers
//   {pc, inst} pairs coming out of fetch so that decode backpressure does not
//   stall fetch directly. Fetch only stalls when the queue is full. A redirect
//   flush drops every buffered entry.
//
// Parameters
//   DEPTH   number of entries (power of 2, >= 2)
//   PC_W    PC width
//   INST_W  instruction width
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous, active-high reset
//   flush      redirect: drop all entries
//   if_valid   fetch presents {if_pc, if_inst}
//   if_pc      PC of fetched instruction
//   if_inst    fetched instruction
//   if_ready   queue can accept an entry
//   id_valid   head entry is valid for decode
//   id_pc      head entry PC (0 when id_valid is low)
//   id_inst    head entry instruction (0 when id_valid is low)
//   id_ready   decode consumes the head this cycle
//   count      current occupancy, 0..DEPTH
//   stall_cnt  (only with IFQ_STALL_CNT_EN defined) saturating count of
//              cycles where fetch had a valid entry but the queue was full
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid/data until the transfer; ready never depends
// on the partner's valid in the same cycle (if_ready uses registered state
// only, id_valid uses registered state only).
//
// Optional feature macro: IFQ_STALL_CNT_EN
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INST_W-1:0]          id_inst,
  input  logic                       id_ready,
`ifdef IFQ_STALL_CNT_EN
  output logic [31:0]                stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  logic push;
  logic pop;

  // Ready is a pure function of registered occupancy (plus reset), so fetch
  // never sees a combinational path from decode.
  assign if_ready = !rst && (cnt_q != FULL_CNT);
  assign id_valid = (cnt_q != '0);
  assign count    = cnt_q;

  assign push = if_valid && if_ready;
  assign pop  = id_valid && id_ready;

  // Head read is combinational; masked so stale storage never leaks out.
  assign id_pc   = id_valid ? pc_mem[rd_ptr]   : '0;
  assign id_inst = id_valid ? inst_mem[rd_ptr] : '0;

  // Pointers and occupancy. Flush shares the reset path: any push or pop in
  // the flush cycle is dropped along with the buffered entries.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; contents are only observable through id_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

`ifdef IFQ_STALL_CNT_EN
  // Counts fetch stalls caused by a full queue. Survives flush so that
  // stall statistics span redirects; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (if_valid && !if_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
//   Directed bench for if_id_queue (DEPTH=4, PC_W=64, INST_W=32). A reference
//   model updated on each rising edge pushes accepted entries into exp_q; a
//   monitor on the falling edge compares the DUT outputs against the model.
//   Directed checks with hand-computed constants cover the named scenarios.
// -----------------------------------------------------------------------------
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst      = 1'b1;
  logic              flush    = 1'b0;
  logic              if_valid = 1'b0;
  logic [PC_W-1:0]   if_pc    = '0;
  logic [INST_W-1:0] if_inst  = '0;
  logic              id_ready = 1'b0;
  logic              if_ready;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic [2:0]        count;
`ifdef IFQ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_ready (id_ready),
`ifdef IFQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .count    (count)
  );

  // ---------------- scoreboard ----------------
  logic [PC_W+INST_W-1:0] exp_q[$];
  logic [31:0]            stall_exp = '0;
  int                     n_cmp = 0;
  int                     n_err = 0;
  bit                     mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: on each edge, apply reset/flush/pop/push to exp_q.
  always @(posedge clk) begin
    int sz;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      stall_exp = '0;
    end else begin
      if (if_valid && sz == DEPTH && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (id_ready && sz != 0) void'(exp_q.pop_front());
        if (if_valid && sz != DEPTH) exp_q.push_back({if_pc, if_inst});
      end
    end
  end

  // Monitor: compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = exp_q.size();
      chk("mon_count",    64'(count),    64'(sz));
      chk("mon_id_valid", 64'(id_valid), 64'(sz != 0));
      chk("mon_if_ready", 64'(if_ready), 64'(!rst && sz != DEPTH));
      if (sz != 0) begin
        chk("mon_id_pc",   id_pc,        exp_q[0][PC_W+INST_W-1:INST_W]);
        chk("mon_id_inst", 64'(id_inst), 64'(exp_q[0][INST_W-1:0]));
      end else begin
        chk("mon_id_pc_zero",   id_pc,        64'd0);
        chk("mon_id_inst_zero", 64'(id_inst), 64'd0);
      end
`ifdef IFQ_STALL_CNT_EN
      chk("mon_stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [63:0] pc, input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = pc[31:0] ^ 32'h0000_0013;
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'd0, rdy, 1'b0);
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset for two cycles.
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    at_neg();
    chk("rst_if_ready_low", 64'(if_ready), 64'd0);
    rst = 1'b0;
    at_neg();
    mon_en = 1'b1;
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc",    id_pc,         64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);

    // Basic: three pushes with decode stalled.
    step(1'b1, 64'h0, 1'b0, 1'b0);
    at_neg();
    chk("basic_first_visible", id_pc, 64'h0);
    chk("basic_first_valid",   64'(id_valid), 64'd1);
    step(1'b1, 64'h4, 1'b0, 1'b0);
    step(1'b1, 64'h8, 1'b0, 1'b0);
    at_neg();
    chk("basic_count3", 64'(count), 64'd3);

    // Fill / backpressure: 4th push fills, 5th is refused.
    step(1'b1, 64'hC, 1'b0, 1'b0);
    at_neg();
    chk("fill_if_ready_low", 64'(if_ready), 64'd0);
    step(1'b1, 64'h10, 1'b0, 1'b0);
    at_neg();
    chk("fill_count4", 64'(count), 64'd4);
    chk("fill_head",   id_pc,       64'h0);

    // Drain from full; the first drain cycle still offers 0x14, which must be ignored.
    step(1'b1, 64'h14, 1'b1, 1'b0);
    at_neg();
    chk("drain_if_ready_up", 64'(if_ready), 64'd1);
    chk("drain_pc1",         id_pc,         64'h4);
    idle(1'b1);
    at_neg();
    chk("drain_pc2", id_pc, 64'h8);
    idle(1'b1);
    at_neg();
    chk("drain_pc3", id_pc, 64'hC);
    idle(1'b1);
    at_neg();
    chk("drain_empty", 64'(count), 64'd0);
    idle(1'b1);  // pop on empty is ignored
    at_neg();
    chk("empty_pop_ignored", 64'(count), 64'd0);

    // Concurrent push+pop at count=2 for 10 cycles, crossing the pointer wrap.
    step(1'b1, 64'h20, 1'b0, 1'b0);
    step(1'b1, 64'h24, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'h28 + 64'(4 * i), 1'b1, 1'b0);
    end
    at_neg();
    chk("conc_count2", 64'(count), 64'd2);
    chk("conc_head",   id_pc,       64'h48);

    // Flush at count=3 with a simultaneous push and pop offered.
    step(1'b1, 64'h50, 1'b0, 1'b0);
    at_neg();
    chk("flush_pre_count3", 64'(count), 64'd3);
    step(1'b1, 64'h100, 1'b1, 1'b1);
    at_neg();
    chk("flush_id_valid", 64'(id_valid), 64'd0);
    chk("flush_count",    64'(count),    64'd0);
    step(1'b1, 64'h200, 1'b0, 1'b0);
    at_neg();
    chk("flush_target_pc", id_pc, 64'h200);

    // Reset mid-operation drops the buffered entry.
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    at_neg();
    chk("midrst_count", 64'(count), 64'd0);

`ifdef IFQ_STALL_CNT_EN
    chk("stall_after_rst", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'h300 + 64'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 64'h400, 1'b0, 1'b0);
    idle(1'b0);
    at_neg();
    chk("stall_cnt7", 64'(stall_cnt), 64'd7);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    at_neg();
    chk("stall_after_flush", 64'(stall_cnt), 64'd7);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    at_neg();
    chk("stall_cleared", 64'(stall_cnt), 64'd0);
`endif

    idle(1'b0);
    idle(1'b0);
    at_neg();
    mon_en = 1'b0;

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
